// File: rtl/debouncer_multi.sv
// Purpose: per-channel synchroniser + saturating stability counter debouncer with optional rise/fall strobes.
// Latency: input change first sampled on edge E0 reaches o_state (and strobes) after edge E0+SYNC_STAGES+PERIOD-1.
// Backpressure: none; every input is sampled each clock and outputs are plain levels/strobes.
// Optional build macro: DEBOUNCER_EDGE_EN builds the o_rise/o_fall/o_any strobe registers; otherwise they are tied to 0.
module debouncer_multi #(
  parameter int CHANNELS    = 4,
  parameter int PERIOD      = 10,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_in,
  output logic [CHANNELS-1:0] o_state,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic                o_any
);

  localparam int             CW      = $clog2(PERIOD + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(PERIOD - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]       cnt_q  [CHANNELS];
  logic [CHANNELS-1:0] state_q;
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] differ;
  logic [CHANNELS-1:0] done;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift each raw input through its synchroniser chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {CHANNELS{INIT_LEVEL}};
      end
    end else begin
      sync_q[0] <= i_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Flag channels whose synchronised sample disagrees, and those that have qualified.
  always_comb begin
    differ = '0;
    done   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      differ[k] = s[k] ^ state_q[k];
      done[k]   = differ[k] && (cnt_q[k] == CNT_MAX);
    end
  end

  // Stability counters and debounced levels; any agreeing sample restarts qualification.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= {CHANNELS{INIT_LEVEL}};
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_q ^ done;
      for (int k = 0; k < CHANNELS; k++) begin
        if (!differ[k] || done[k]) begin
          cnt_q[k] <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + CW'(1);
        end
      end
    end
  end

  assign o_state = state_q;

`ifdef DEBOUNCER_EDGE_EN
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;

  // Strobes register on the same edge as the level change, so they line up with the new o_state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= done & s;
      fall_q <= done & ~s;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_any  = |(rise_q | fall_q);
`else
  assign o_rise = '0;
  assign o_fall = '0;
  assign o_any  = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// Purpose: directed, table-driven checks of debouncer_multi with default parameters.
// Latency: expected changes land 12 cycles after an input row is applied (E0 is cycle 1).
// Backpressure: not applicable; stimulus is applied freely each cycle.
module tb_debouncer_multi;

`ifdef DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_v;
  logic [3:0] state_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic       any_o;

  int checks = 0;
  int errors = 0;

  debouncer_multi #(
    .CHANNELS   (4),
    .PERIOD     (10),
    .SYNC_STAGES(2),
    .INIT_LEVEL (1'b0)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_in   (in_v),
    .o_state(state_o),
    .o_rise (rise_o),
    .o_fall (fall_o),
    .o_any  (any_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    int         hold;
    int         chg_at;  // cycle (1 = first edge after applying) of the state change, 0 = none
    logic [3:0] nxt;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t vecs[$];

  // Compare every output against the expected state and strobes.
  task automatic check(input string name, input int row, input int cyc,
                       input logic [3:0] es, input logic [3:0] er, input logic [3:0] ef);
    logic [3:0] xr;
    logic [3:0] xf;
    logic       xa;
    xr = EDGE_EN ? er : 4'b0000;
    xf = EDGE_EN ? ef : 4'b0000;
    xa = |(xr | xf);
    checks++;
    if (state_o !== es || rise_o !== xr || fall_o !== xf || any_o !== xa) begin
      errors++;
      $display("FAIL %s row%0d cyc%0d: got state=%b rise=%b fall=%b any=%b, want state=%b rise=%b fall=%b any=%b",
               name, row, cyc, state_o, rise_o, fall_o, any_o, es, xr, xf, xa);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] cur;
    logic [3:0] es;
    logic [3:0] er;
    logic [3:0] ef;

    // Vector table: idle, clean press, glitch, bounce up/down, simultaneous, release.
    vecs.push_back('{4'b0000, 15, 0,  4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0001, 30, 12, 4'b0001, 4'b0001, 4'b0000});
    vecs.push_back('{4'b0011, 9,  0,  4'b0001, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0001, 40, 0,  4'b0001, 4'b0000, 4'b0000});
    for (int i = 0; i < 5; i++) begin
      vecs.push_back('{4'b0101, 3, 0, 4'b0001, 4'b0000, 4'b0000});
      vecs.push_back('{4'b0001, 3, 0, 4'b0001, 4'b0000, 4'b0000});
    end
    vecs.push_back('{4'b0101, 30, 12, 4'b0101, 4'b0100, 4'b0000});
    for (int i = 0; i < 5; i++) begin
      vecs.push_back('{4'b0001, 3, 0, 4'b0101, 4'b0000, 4'b0000});
      vecs.push_back('{4'b0101, 3, 0, 4'b0101, 4'b0000, 4'b0000});
    end
    vecs.push_back('{4'b0001, 30, 12, 4'b0001, 4'b0000, 4'b0100});
    vecs.push_back('{4'b1000, 30, 12, 4'b1000, 4'b1000, 4'b0001});
    vecs.push_back('{4'b0000, 30, 12, 4'b0000, 4'b0000, 4'b1000});

    // Reset held with all inputs high: everything stays at the reset value.
    rst_n = 1'b0;
    in_v  = 4'hF;
    #1;
    check("reset_async", -1, 0, 4'b0000, 4'b0000, 4'b0000);
    for (int c = 1; c <= 5; c++) begin
      step();
      check("reset_hold", -1, c, 4'b0000, 4'b0000, 4'b0000);
    end
    in_v  = 4'h0;
    rst_n = 1'b1;

    // Table-driven rows; every cycle is watched for unexpected changes.
    cur = 4'b0000;
    for (int r = 0; r < vecs.size(); r++) begin
      in_v = vecs[r].in;
      for (int c = 1; c <= vecs[r].hold; c++) begin
        step();
        es = (vecs[r].chg_at != 0 && c >= vecs[r].chg_at) ? vecs[r].nxt : cur;
        er = (c == vecs[r].chg_at) ? vecs[r].rise : 4'b0000;
        ef = (c == vecs[r].chg_at) ? vecs[r].fall : 4'b0000;
        check("vector", r, c, es, er, ef);
      end
      if (vecs[r].chg_at != 0) cur = vecs[r].nxt;
    end

    // Reset mid-count: count reaches 5 on edge 7, then reset discards it.
    in_v = 4'b0010;
    for (int c = 1; c <= 7; c++) begin
      step();
      check("midcnt_pre", -2, c, 4'b0000, 4'b0000, 4'b0000);
    end
    rst_n = 1'b0;
    #1;
    check("midcnt_async", -2, 0, 4'b0000, 4'b0000, 4'b0000);
    for (int c = 1; c <= 2; c++) begin
      step();
      check("midcnt_rst", -2, c, 4'b0000, 4'b0000, 4'b0000);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      es = (c >= 12) ? 4'b0010 : 4'b0000;
      er = (c == 12) ? 4'b0010 : 4'b0000;
      check("midcnt_post", -2, c, es, er, 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debouncer_multi.md
# debouncer_multi

Parametrised multi-channel switch/button debouncer. It is the successor to the single-channel debouncer. Each of CHANNELS asynchronous inputs passes through its own synchroniser and stability counter, and drives a debounced level plus optional one-cycle rise/fall strobes. It sits between raw board pins (buttons, DIP switches, mechanical contacts) and synchronous control logic.

## Interface
Parameters:
- CHANNELS, default 4: number of independent channels, 1..32.
- PERIOD, default 10: number of consecutive clocks a synchronised input must differ from the debounced level before that level changes, ≥1.
- SYNC_STAGES, default 2: synchroniser flops per channel, ≥2.
- INIT_LEVEL, default 0: reset value (1 bit) of the synchroniser flops and the debounced level, applied to all channels.

Ports:
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_in, input, CHANNELS: raw, asynchronous inputs.
- o_state, output, CHANNELS: debounced level per channel.
- o_rise, output, CHANNELS: one-cycle strobe when o_state goes 0→1.
- o_fall, output, CHANNELS: one-cycle strobe when o_state goes 1→0.
- o_any, output, 1: OR of all bits of o_rise and o_fall.

## Operation
- Channels are fully independent. There is no shared counter and no arbitration.
- Synchroniser: i_in[k] is shifted through a chain of SYNC_STAGES flops. s[k] is the last stage.
- Counter: cnt[k] is $clog2(PERIOD+1) bits wide and saturates; it never wraps.
  - If s[k] == o_state[k]: cnt[k] ← 0.
  - Else if cnt[k] == PERIOD-1: o_state[k] ← s[k] and cnt[k] ← 0.
  - Else: cnt[k] ← cnt[k]+1.
- Any sample equal to o_state[k] restarts qualification. Glitches and bounces shorter than PERIOD clocks never reach o_state.
- PERIOD == 1: o_state[k] follows s[k] with one clock of delay.
- Strobes are registered. o_rise[k] and o_fall[k] are high for exactly the one clock following the edge on which o_state[k] changes, i.e. coincident with the new o_state value. They are never both high on one channel.
- Several channels may change on the same clock; every strobe asserts, and o_any asserts once.
- Reset values while i_rst_n = 0:
  - synchroniser flops = INIT_LEVEL
  - o_state = {CHANNELS{INIT_LEVEL}}
  - cnt = 0
  - o_rise = o_fall = o_any = 0
- Reset release never produces a strobe.
- Reset asserted mid-count discards the partial count. Qualification restarts from zero after release.

## Timing
- Latency: a clean level change on i_in[k], first sampled on edge E0, appears on o_state[k] after edge E0 + SYNC_STAGES + PERIOD − 1. With defaults, 11 edges after E0. The strobe is visible during the same cycle.
- A pulse held for fewer than PERIOD consecutive synchronised samples produces no output change.
- o_state, o_rise and o_fall come directly from flops. o_any is a single OR stage of registered bits.
- Reset assertion is asynchronous and takes effect immediately. Release is expected to be synchronised to i_clk upstream.

## Configuration
- DEBOUNCER_EDGE_EN defined:
  - rise/fall strobe registers are built and o_rise, o_fall and o_any behave as above.
- Undefined:
  - strobe logic is omitted.
  - o_rise, o_fall and o_any are tied to 0.
  - Ports remain present; o_state behaviour and latency are unchanged.

## Test plan
Bench settings: CHANNELS=4, PERIOD=10, SYNC_STAGES=2, INIT_LEVEL=0, DEBOUNCER_EDGE_EN defined unless stated. A watchdog fails on any unexpected o_state change.
- Reset: hold i_rst_n=0 for 5 clocks with i_in=4'hF → o_state=0, o_rise=o_fall=0, o_any=0 throughout. No strobe on release.
- Clean press: i_in[0]=1 and held for 30 clocks → o_state[0]=1 exactly 11 edges after first sampling. o_rise[0] and o_any are high for exactly 1 cycle; other channels stay 0.
- Glitch rejection: i_in[1] high for 9 clocks, then low → o_state[1] stays 0 and no strobe, checked over 40 clocks.
- Bounce: i_in[2] toggles every 3 clocks for 30 clocks, then holds 1 → one o_rise[2], 11 edges after the final transition. Release the same way → one o_fall[2].
- Simultaneous events: with o_state[0]=1, drop i_in[0] and raise i_in[3] on the same clock → o_fall[0] and o_rise[3] in the same cycle, o_any high for 1 cycle.
- Reset mid-count: raise i_in[1], assert i_rst_n for 2 clocks at count 5, release with i_in[1] still 1 → o_state[1] rises 11 edges after release. Rebuild without DEBOUNCER_EDGE_EN → o_state is identical and o_rise/o_fall/o_any stay 0.
